sisc_ctrl_fsm: RTL and testbench

//  Parametrised successor of the SISC control FSM. Sequences fetch/decode/execute/mem/writeback
//  per instruction class, skipping unused states. Adds a mem_ready wait handshake with timeout,

---
 rtl/sisc_pkg.sv | 39 +++
 rtl/sisc_perf_cnt.sv | 39 +++
 rtl/sisc_ctrl_fsm.sv | 184 ++++++++++++++++++
 tb/tb_sisc_ctrl_fsm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared constants and types for the SISC control FSM
//
// Purpose: opcode values, the immediate addressing-mode code, FSM state
// encoding and ALU operation encodings used by sisc_ctrl_fsm.
// Ports: none (package).

package sisc_pkg;

  // Opcodes (IR[31:28]); values 9..14 are undefined and treated as NOOP
  localparam int OP_NOOP = 0;
  localparam int OP_LOD  = 1;
  localparam int OP_STR  = 2;
  localparam int OP_SWP  = 3;
  localparam int OP_BRA  = 4;
  localparam int OP_BRR  = 5;
  localparam int OP_BNE  = 6;
  localparam int OP_BNR  = 7;
  localparam int OP_ALU  = 8;
  localparam int OP_HLT  = 15;

  // mm value selecting the immediate operand for ALU instructions
  localparam int AM_IMM = 8;

  typedef enum logic [2:0] {
    S_START0    = 3'd0,
    S_START1    = 3'd1,
    S_FETCH     = 3'd2,
    S_DECODE    = 3'd3,
    S_EXECUTE   = 3'd4,
    S_MEM       = 3'd5,
    S_WRITEBACK = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [1:0] ALU_RR   = 2'b00;
  localparam logic [1:0] ALU_IMM  = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

endpackage

// File: rtl/sisc_perf_cnt.sv
// rtl/sisc_perf_cnt.sv - instruction and memory-stall performance counters
//
// Purpose: counts fetched instructions and MEM cycles spent waiting on memory.
// Both counters wrap and clear on reset. The FSM never fetches or enters MEM
// while halted, so the counts freeze in HALT without extra gating.
// Ports:
//   clk          in   system clock
//   rst_f        in   asynchronous active-low reset
//   i_fetch      in   FSM is in FETCH this cycle
//   i_stall      in   FSM is in MEM and memory is not ready this cycle
//   o_instr_cnt  out  number of FETCH cycles since reset
//   o_stall_cnt  out  number of stalled MEM cycles since reset

module sisc_perf_cnt (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        i_fetch,
  input  logic        i_stall,
  output logic [31:0] o_instr_cnt,
  output logic [31:0] o_stall_cnt
);

  logic [31:0] r_instr_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_instr_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (i_fetch) r_instr_cnt <= r_instr_cnt + 32'd1;
      if (i_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_instr_cnt = r_instr_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/sisc_ctrl_fsm.sv
// rtl/sisc_ctrl_fsm.sv - SISC control FSM with memory wait/timeout and HALT
//
// Purpose: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction class,
// evaluates branches in DECODE, waits on mem_ready in MEM with a timeout that
// raises a sticky mem_err and halts. Control outputs are decoded from the
// current state plus opcode/mm/stat.
// Optional feature: define SISC_PERF_CNT_EN to add instr_cnt/stall_cnt outputs.
// Ports:
//   clk, rst_f (async active-low)
//   opcode, mm, stat  in   instruction fields and status flags
//   mem_ready         in   data memory access complete
//   rf_we, wb_sel, br_sel, pc_sel, ir_load, pc_write, pc_rst, rb_sel, mm_we
//                     out  datapath control strobes
//   alu_op            out  00 reg-reg, 01 immediate/address, 10 pass
//   halted            out  FSM in HALT
//   mem_err           out  sticky memory-timeout flag
//   instr_cnt, stall_cnt (SISC_PERF_CNT_EN only) performance counters

module sisc_ctrl_fsm
  import sisc_pkg::*;
#(
  parameter int OP_W     = 4,
  parameter int ALU_OP_W = 2,
  parameter int WAIT_W   = 4
) (
  input  logic                clk,
  input  logic                rst_f,
  input  logic [OP_W-1:0]     opcode,
  input  logic [OP_W-1:0]     mm,
  input  logic [OP_W-1:0]     stat,
  input  logic                mem_ready,
  output logic                rf_we,
  output logic                wb_sel,
  output logic                br_sel,
  output logic                pc_sel,
  output logic                ir_load,
  output logic                pc_write,
  output logic                pc_rst,
  output logic                rb_sel,
  output logic                mm_we,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                halted,
  output logic                mem_err
`ifdef SISC_PERF_CNT_EN
  ,
  output logic [31:0]         instr_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  localparam logic [WAIT_W-1:0] L_WAIT_MAX = '1;

  state_t            r_state;
  logic [WAIT_W-1:0] r_cnt;
  logic              r_mem_err;

  logic w_is_lod, w_is_str, w_is_swp, w_is_alu, w_is_hlt;
  logic w_is_bra, w_is_brr, w_is_bne, w_is_bnr;
  logic w_is_exec, w_is_mem_op, w_flag, w_taken, w_br_abs;
  logic [1:0]        w_alu_cls;
  logic [1:0]        w_alu;
  logic [WAIT_W-1:0] w_cnt_inc;

  assign w_is_lod = (opcode == OP_W'(OP_LOD));
  assign w_is_str = (opcode == OP_W'(OP_STR));
  assign w_is_swp = (opcode == OP_W'(OP_SWP));
  assign w_is_alu = (opcode == OP_W'(OP_ALU));
  assign w_is_hlt = (opcode == OP_W'(OP_HLT));
  assign w_is_bra = (opcode == OP_W'(OP_BRA));
  assign w_is_brr = (opcode == OP_W'(OP_BRR));
  assign w_is_bne = (opcode == OP_W'(OP_BNE));
  assign w_is_bnr = (opcode == OP_W'(OP_BNR));

  // NOOP, branches and undefined opcodes all return to FETCH from DECODE
  assign w_is_exec   = w_is_lod | w_is_str | w_is_swp | w_is_alu;
  assign w_is_mem_op = w_is_lod | w_is_str;

  assign w_flag   = |(stat & mm);
  assign w_taken  = ((w_is_bra | w_is_brr) & w_flag) | ((w_is_bne | w_is_bnr) & ~w_flag);
  assign w_br_abs = w_is_bra | w_is_bne;

  // ALU operation shared by EXECUTE, MEM and WRITEBACK of one instruction
  always_comb begin
    w_alu_cls = ALU_PASS;
    if (w_is_alu)         w_alu_cls = (mm == OP_W'(AM_IMM)) ? ALU_IMM : ALU_RR;
    else if (w_is_mem_op) w_alu_cls = ALU_IMM;
  end

  // Count including the current MEM cycle, so the timeout fires at the end of
  // the (2**WAIT_W-1)th consecutive MEM cycle without mem_ready.
  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      r_state   <= S_START1;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      case (r_state)
        S_START0:    r_state <= S_START1;
        S_START1:    r_state <= S_FETCH;
        S_FETCH:     r_state <= S_DECODE;
        S_DECODE: begin
          if (w_is_hlt)       r_state <= S_HALT;
          else if (w_is_exec) r_state <= S_EXECUTE;
          else                r_state <= S_FETCH;
        end
        S_EXECUTE:   r_state <= w_is_mem_op ? S_MEM : S_WRITEBACK;
        S_MEM: begin
          if (mem_ready) begin
            r_cnt   <= '0;
            r_state <= w_is_lod ? S_WRITEBACK : S_FETCH;
          end else if (w_cnt_inc == L_WAIT_MAX) begin
            r_cnt     <= '0;
            r_mem_err <= 1'b1;
            r_state   <= S_HALT;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WRITEBACK: r_state <= S_FETCH;
        S_HALT:      r_state <= S_HALT;
        default:     r_state <= S_START1;
      endcase
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_sel   = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_rst   = 1'b0;
    rb_sel   = 1'b0;
    mm_we    = 1'b0;
    w_alu    = ALU_PASS;
    case (r_state)
      S_START0, S_START1: pc_rst = 1'b1;
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        pc_write = w_taken;
        pc_sel   = w_taken;
        br_sel   = w_taken & w_br_abs;
      end
      S_EXECUTE: begin
        w_alu  = w_alu_cls;
        rb_sel = w_is_swp | w_is_str;
      end
      S_MEM: begin
        w_alu  = w_alu_cls;
        mm_we  = w_is_str;
        rb_sel = w_is_str;
      end
      S_WRITEBACK: begin
        w_alu  = w_alu_cls;
        rf_we  = 1'b1;
        wb_sel = w_is_lod;
        rb_sel = w_is_swp;
      end
      default: ;
    endcase
  end

  assign alu_op  = ALU_OP_W'(w_alu);
  assign halted  = (r_state == S_HALT);
  assign mem_err = r_mem_err;

`ifdef SISC_PERF_CNT_EN
  sisc_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst_f       (rst_f),
    .i_fetch     (r_state == S_FETCH),
    .i_stall     ((r_state == S_MEM) && !mem_ready),
    .o_instr_cnt (instr_cnt),
    .o_stall_cnt (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_sisc_ctrl_fsm.sv
// tb/tb_sisc_ctrl_fsm.sv - self-checking bench for sisc_ctrl_fsm

module tb_sisc_ctrl_fsm;

  localparam logic [3:0] NOOP = 4'd0, LOD = 4'd1, STR = 4'd2, SWP = 4'd3;
  localparam logic [3:0] BRA = 4'd4, BRR = 4'd5, BNE = 4'd6, BNR = 4'd7;
  localparam logic [3:0] ALU = 4'd8, HLT = 4'd15;
  localparam int TIMEOUT_CYCLES = 15;

  logic       clk = 1'b0;
  logic       rst_f = 1'b0;
  logic [3:0] opcode = 4'd0, mm = 4'd0, stat = 4'd0;
  logic       mem_ready = 1'b0;
  logic       rf_we, wb_sel, br_sel, pc_sel, ir_load, pc_write, pc_rst, rb_sel, mm_we;
  logic [1:0] alu_op;
  logic       halted, mem_err;
`ifdef SISC_PERF_CNT_EN
  logic [31:0] instr_cnt, stall_cnt;
`endif

  sisc_ctrl_fsm dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .opcode    (opcode),
    .mm        (mm),
    .stat      (stat),
    .mem_ready (mem_ready),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .br_sel    (br_sel),
    .pc_sel    (pc_sel),
    .ir_load   (ir_load),
    .pc_write  (pc_write),
    .pc_rst    (pc_rst),
    .rb_sel    (rb_sel),
    .mm_we     (mm_we),
    .alu_op    (alu_op),
    .halted    (halted),
    .mem_err   (mem_err)
`ifdef SISC_PERF_CNT_EN
    ,
    .instr_cnt (instr_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic        chk_en = 1'b0;
  logic [12:0] exp_vec = '0;
  logic        model_err = 1'b0;
  int          n_fetch = 0;
  int          n_stall = 0;

  // Expected output vector: {halted, mem_err, alu_op, rf_we, wb_sel, br_sel,
  // pc_sel, ir_load, pc_write, pc_rst, rb_sel, mm_we}
  function automatic logic [12:0] v(input logic h, me, input logic [1:0] ao,
                                    input logic rf, wb, br, ps, ir, pw, pr, rb, mw);
    return {h, me, ao, rf, wb, br, ps, ir, pw, pr, rb, mw};
  endfunction

  wire [12:0] got_vec = {halted, mem_err, alu_op, rf_we, wb_sel, br_sel, pc_sel,
                         ir_load, pc_write, pc_rst, rb_sel, mm_we};

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (got_vec !== exp_vec) begin
        failures++;
        $display("FAIL outputs cycle=%0d op=%0d got=%b required=%b", cyc, opcode, got_vec, exp_vec);
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step(input logic [12:0] e, input logic mr,
                      input logic [3:0] op, input logic [3:0] m, input logic [3:0] s);
    @(posedge clk);
    #1;
    opcode    = op;
    mm        = m;
    stat      = s;
    mem_ready = mr;
    exp_vec   = e;
    chk_en    = 1'b1;
    cyc++;
  endtask

  task automatic halt_cycles(input int n);
    repeat (n) step(v(1, model_err, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, opcode, mm, stat);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    chk_en = 1'b0;
    rst_f  = 1'b0;
    #1;
    lit("rst_pc_rst", {31'd0, pc_rst}, 32'd1);
    lit("rst_mm_we", {31'd0, mm_we}, 32'd0);
    lit("rst_mem_err", {31'd0, mem_err}, 32'd0);
    lit("rst_halted", {31'd0, halted}, 32'd0);
    model_err = 1'b0;
    n_fetch   = 0;
    n_stall   = 0;
    step(v(0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0, NOOP, 4'd0, 4'd0);
    step(v(0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 1, 0, 0), 1'b0, NOOP, 4'd0, 4'd0);
    rst_f = 1'b1;
  endtask

  // One instruction from FETCH to its last cycle, outputs derived from the
  // instruction class rules. waits = MEM cycles with mem_ready low before it
  // rises (>= timeout means never); abort_mem > 0 stops after that many MEM cycles.
  task automatic run_instr(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                           input int waits, input int abort_mem);
    logic       t, taken, is_abs, is_str, is_lod, is_ls;
    logic [1:0] ao;
    logic [12:0] mem_v;
    step(v(0, 0, 2'b10, 0, 0, 0, 0, 1, 1, 0, 0, 0), 1'b0, op, m, s);
    n_fetch++;
    t      = |(s & m);
    taken  = ((op == BRA || op == BRR) && t) || ((op == BNE || op == BNR) && !t);
    is_abs = (op == BRA || op == BNE);
    step(v(0, 0, 2'b10, 0, 0, taken && is_abs, taken, 0, taken, 0, 0, 0), 1'b0, op, m, s);
    if (op == HLT) return;
    if (!(op == LOD || op == STR || op == SWP || op == ALU)) return;
    is_str = (op == STR);
    is_lod = (op == LOD);
    is_ls  = is_str || is_lod;
    if (is_ls)          ao = 2'b01;
    else if (op == SWP) ao = 2'b10;
    else                ao = (m == 4'd8) ? 2'b01 : 2'b00;
    step(v(0, 0, ao, 0, 0, 0, 0, 0, 0, 0, is_str || op == SWP, 0), 1'b0, op, m, s);
    if (is_ls) begin
      mem_v = v(0, 0, ao, 0, 0, 0, 0, 0, 0, 0, is_str, is_str);
      if (abort_mem > 0) begin
        repeat (abort_mem) step(mem_v, 1'b0, op, m, s);
        return;
      end
      if (waits >= TIMEOUT_CYCLES) begin
        repeat (TIMEOUT_CYCLES) step(mem_v, 1'b0, op, m, s);
        n_stall += TIMEOUT_CYCLES;
        model_err = 1'b1;
        return;
      end
      repeat (waits) step(mem_v, 1'b0, op, m, s);
      step(mem_v, 1'b1, op, m, s);
      n_stall += waits;
      if (is_str) return;
    end
    step(v(0, 0, ao, 1, is_lod, 0, 0, 0, 0, 0, op == SWP, 0), 1'b0, op, m, s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply_reset();

    run_instr(ALU, 4'd0, 4'd0, 0, 0);
    run_instr(ALU, 4'd8, 4'd0, 0, 0);

    // Taken absolute branch, checked literally in DECODE
    step(v(0, 0, 2'b10, 0, 0, 0, 0, 1, 1, 0, 0, 0), 1'b0, BRA, 4'b0010, 4'b0010);
    n_fetch++;
    step(v(0, 0, 2'b10, 0, 0, 1, 1, 0, 1, 0, 0, 0), 1'b0, BRA, 4'b0010, 4'b0010);
    #1;
    lit("bra_pc_write", {31'd0, pc_write}, 32'd1);
    lit("bra_pc_sel", {31'd0, pc_sel}, 32'd1);
    lit("bra_br_sel", {31'd0, br_sel}, 32'd1);
    run_instr(BRA, 4'b0010, 4'b0000, 0, 0);
    run_instr(BRR, 4'b0001, 4'b0001, 0, 0);
    run_instr(BNE, 4'b0001, 4'b0000, 0, 0);
    run_instr(BNE, 4'b0001, 4'b0001, 0, 0);
    run_instr(BNR, 4'b0011, 4'b0010, 0, 0);
    run_instr(BNR, 4'b1100, 4'b0011, 0, 0);
    run_instr(NOOP, 4'd0, 4'd0, 0, 0);
    run_instr(4'd11, 4'd3, 4'd3, 0, 0);
    run_instr(SWP, 4'd0, 4'd0, 0, 0);
    run_instr(STR, 4'd0, 4'd0, 0, 0);
    run_instr(STR, 4'd0, 4'd0, 2, 0);
    run_instr(LOD, 4'd0, 4'd0, 0, 0);
    run_instr(LOD, 4'd0, 4'd0, 3, 0);
    #1;
    lit("lod_wb_sel", {31'd0, wb_sel}, 32'd1);
    lit("lod_rf_we", {31'd0, rf_we}, 32'd1);

    // Reset in the middle of a store's MEM phase
    run_instr(STR, 4'd0, 4'd0, 0, 3);
    apply_reset();
    run_instr(ALU, 4'd0, 4'd0, 0, 0);

    // Store that never completes: 15 MEM cycles then timeout halt
    run_instr(STR, 4'd0, 4'd0, TIMEOUT_CYCLES, 0);
    halt_cycles(5);
    #1;
    lit("timeout_mem_err", {31'd0, mem_err}, 32'd1);
    lit("timeout_halted", {31'd0, halted}, 32'd1);
    apply_reset();

    // Memory ready on the last MEM cycle before the timeout would fire
    run_instr(LOD, 4'd0, 4'd0, TIMEOUT_CYCLES - 1, 0);
    run_instr(ALU, 4'd8, 4'd0, 0, 0);
    run_instr(HLT, 4'd0, 4'd0, 0, 0);
    halt_cycles(1);
`ifdef SISC_PERF_CNT_EN
    #1;
    lit("instr_cnt_halt", instr_cnt, 32'(n_fetch));
    lit("stall_cnt_halt", stall_cnt, 32'(n_stall));
    lit("instr_cnt_literal", instr_cnt, 32'd3);
`endif
    halt_cycles(19);
    #1;
    lit("hlt_halted", {31'd0, halted}, 32'd1);
    lit("hlt_mem_err", {31'd0, mem_err}, 32'd0);
`ifdef SISC_PERF_CNT_EN
    lit("instr_cnt_frozen", instr_cnt, 32'(n_fetch));
    lit("stall_cnt_frozen", stall_cnt, 32'd14);
`endif

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
